// File: rtl/sym_tap_line.sv
// Signed sample delay line with registered symmetric pre-add, fill count and primed flag.
// Optional synchronous clear port enabled by defining SYM_TAP_CLEAR_EN.
module sym_tap_line #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int HALF  = (DEPTH + 1) / 2,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [WIDTH-1:0]            sin,
`ifdef SYM_TAP_CLEAR_EN
    input  logic                        clr,
`endif
    output logic [DEPTH*WIDTH-1:0]      taps,
    output logic [HALF*(WIDTH+1)-1:0]   pair_sum,
    output logic                        pair_valid,
    output logic [FW-1:0]               fill,
    output logic                        primed
);

    logic [WIDTH-1:0] tap_reg   [DEPTH];
    logic [WIDTH:0]   pair_reg  [HALF];
    logic [WIDTH:0]   pair_next [HALF];
    logic             en_reg;
    logic             valid_reg;
    logic [FW-1:0]    fill_reg;
    logic             clear;

`ifdef SYM_TAP_CLEAR_EN
    assign clear = clr;
`else
    assign clear = 1'b0;
`endif

    // Folded sums are formed one bit wider so the add can never overflow.
    generate
        for (genvar gi = 0; gi < HALF; gi++) begin : g_pair
            if (2 * gi + 1 == DEPTH) begin : g_mid
                assign pair_next[gi] = {tap_reg[gi][WIDTH-1], tap_reg[gi]};
            end else begin : g_fold
                assign pair_next[gi] = {tap_reg[gi][WIDTH-1], tap_reg[gi]}
                                     + {tap_reg[DEPTH-1-gi][WIDTH-1], tap_reg[DEPTH-1-gi]};
            end
            assign pair_sum[gi*(WIDTH+1) +: (WIDTH+1)] = pair_reg[gi];
        end
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap_out
            assign taps[gi*WIDTH +: WIDTH] = tap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tap_reg[i] <= '0;
            for (int i = 0; i < HALF; i++)  pair_reg[i] <= '0;
            en_reg    <= 1'b0;
            valid_reg <= 1'b0;
            fill_reg  <= '0;
        end else if (clear) begin
            // Clear beats a simultaneous shift: the incoming sample is dropped.
            for (int i = 0; i < DEPTH; i++) tap_reg[i] <= '0;
            for (int i = 0; i < HALF; i++)  pair_reg[i] <= '0;
            en_reg    <= 1'b0;
            valid_reg <= 1'b0;
            fill_reg  <= '0;
        end else begin
            if (en) begin
                tap_reg[0] <= sin;
                for (int i = 1; i < DEPTH; i++) tap_reg[i] <= tap_reg[i-1];
                if (fill_reg != FW'(DEPTH)) fill_reg <= fill_reg + FW'(1);
            end
            for (int i = 0; i < HALF; i++) pair_reg[i] <= pair_next[i];
            // Valid tracks the pair register, which lags the shift by one edge.
            en_reg    <= en;
            valid_reg <= en_reg;
        end
    end

    assign pair_valid = valid_reg;
    assign fill       = fill_reg;
    assign primed     = (fill_reg == FW'(DEPTH));

endmodule

// File: tb/tb_sym_tap_line.sv
// Bench for sym_tap_line: DEPTH=4 and DEPTH=5 instances (WIDTH=8) against a queue-style reference model.
module tb_sym_tap_line;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  sin = 8'd0;

    logic [31:0] taps4;
    logic [17:0] pair4;
    logic        valid4;
    logic [2:0]  fill4;
    logic        primed4;
    logic [39:0] taps5;
    logic [26:0] pair5;
    logic        valid5;
    logic [2:0]  fill5;
    logic        primed5;

    always #5 clk = ~clk;

    sym_tap_line #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .sin(sin),
`ifdef SYM_TAP_CLEAR_EN
        .clr(clr),
`endif
        .taps(taps4), .pair_sum(pair4), .pair_valid(valid4), .fill(fill4), .primed(primed4)
    );

    sym_tap_line #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .sin(sin),
`ifdef SYM_TAP_CLEAR_EN
        .clr(clr),
`endif
        .taps(taps5), .pair_sum(pair5), .pair_valid(valid5), .fill(fill5), .primed(primed5)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sample windows as integer arrays, newest first.
    int m4[4];
    int m5[5];
    int p4[2];
    int p5[3];
    int f4, f5;
    bit pend, v;
    logic [31:0] x_taps4;
    logic [17:0] x_pair4;
    logic [39:0] x_taps5;
    logic [26:0] x_pair5;

    task automatic build_expected();
        for (int k = 0; k < 4; k++) x_taps4[k*8 +: 8] = 8'(m4[k]);
        for (int k = 0; k < 5; k++) x_taps5[k*8 +: 8] = 8'(m5[k]);
        for (int k = 0; k < 2; k++) x_pair4[k*9 +: 9] = 9'(p4[k]);
        for (int k = 0; k < 3; k++) x_pair5[k*9 +: 9] = 9'(p5[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m4[k] = 0;
        for (int k = 0; k < 5; k++) m5[k] = 0;
        for (int k = 0; k < 2; k++) p4[k] = 0;
        for (int k = 0; k < 3; k++) p5[k] = 0;
        f4 = 0; f5 = 0; pend = 1'b0; v = 1'b0;
        build_expected();
    endtask

    task automatic cycle(input bit e, input int s, input bit c);
        en = e; sin = 8'(s); clr = c;
        @(posedge clk); #1;
        p4[0] = m4[0] + m4[3];
        p4[1] = m4[1] + m4[2];
        p5[0] = m5[0] + m5[4];
        p5[1] = m5[1] + m5[3];
        p5[2] = m5[2];
        v    = pend;
        pend = e && !c;
        if (c) begin
            model_reset();
        end else if (e) begin
            for (int i = 3; i > 0; i--) m4[i] = m4[i-1];
            for (int i = 4; i > 0; i--) m5[i] = m5[i-1];
            m4[0] = s; m5[0] = s;
            if (f4 < 4) f4++;
            if (f5 < 5) f5++;
        end
        build_expected();
        $display("cyc t=%0t en=%0b sin=%0d clr=%0b taps4=%h pair4=%h v4=%0b fill4=%0d pair5=%h",
                 $time, e, s, c, taps4, pair4, valid4, fill4, pair5);
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0;
        rst = 1'b0; #2; rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (taps4 !== 32'd0) begin errors++; $display("FAIL reset_taps4 got %h want 0", taps4); end
        checks++; if (pair4 !== 18'd0) begin errors++; $display("FAIL reset_pair4 got %h want 0", pair4); end
        checks++; if (valid4 !== 1'b0 || valid5 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", valid4, valid5); end
        checks++; if (fill4 !== 3'd0 || primed4 !== 1'b0) begin errors++; $display("FAIL reset_fill4 got %0d/%b want 0/0", fill4, primed4); end
        checks++; if (taps5 !== 40'd0 || pair5 !== 27'd0) begin errors++; $display("FAIL reset_dut5 got %h/%h want 0", taps5, pair5); end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_count_up();
        int pulses = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, i, 1'b0);
            if (valid4 === 1'b1) pulses++;
            checks++; if (taps4 !== x_taps4) begin errors++; $display("FAIL count_taps4 got %h want %h", taps4, x_taps4); end
        end
        checks++; if (taps4 !== {8'd1, 8'd2, 8'd3, 8'd4}) begin errors++; $display("FAIL count_taps4_const got %h want 01020304", taps4); end
        checks++; if (fill4 !== 3'd4 || primed4 !== 1'b1) begin errors++; $display("FAIL count_primed got %0d/%b want 4/1", fill4, primed4); end
        cycle(1'b0, 0, 1'b0);
        if (valid4 === 1'b1) pulses++;
        checks++; if (pair4 !== {9'd5, 9'd5}) begin errors++; $display("FAIL count_pair4 got %h want %h", pair4, {9'd5, 9'd5}); end
        checks++; if (pulses != 4) begin errors++; $display("FAIL count_pulses got %0d want 4", pulses); end
        cycle(1'b1, 5, 1'b0);
        cycle(1'b0, 0, 1'b0);
        checks++; if (pair5 !== {9'd3, 9'd6, 9'd6}) begin errors++; $display("FAIL odd_pair5 got %h want %h", pair5, {9'd3, 9'd6, 9'd6}); end
        checks++; if (primed5 !== 1'b1 || pair5 !== x_pair5) begin errors++; $display("FAIL odd_model got %h/%b want %h/1", pair5, primed5, x_pair5); end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 127, 1'b0);
        cycle(1'b1, -128, 1'b0);
        checks++; if (pair4 !== {9'd254, 9'd254}) begin errors++; $display("FAIL ext_254 got %h want %h", pair4, {9'd254, 9'd254}); end
        cycle(1'b1, -128, 1'b0);
        cycle(1'b1, -128, 1'b0);
        checks++; if (pair4 !== {9'h1FF, 9'h1FF}) begin errors++; $display("FAIL ext_mixed got %h want %h", pair4, {9'h1FF, 9'h1FF}); end
        cycle(1'b1, -128, 1'b0);
        cycle(1'b0, 0, 1'b0);
        checks++; if (pair4 !== {9'h100, 9'h100}) begin errors++; $display("FAIL ext_neg256 got %h want %h", pair4, {9'h100, 9'h100}); end
        checks++; if (pair4 !== x_pair4) begin errors++; $display("FAIL ext_model got %h want %h", pair4, x_pair4); end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        do_reset();
        cycle(1'b1, 1, 1'b0);
        if (valid4 === 1'b1) pulses++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 0, 1'b0);
            if (valid4 === 1'b1) pulses++;
            checks++; if (taps4 !== 32'h0000_0001) begin errors++; $display("FAIL gap_hold got %h want 00000001", taps4); end
        end
        cycle(1'b1, 2, 1'b0);
        if (valid4 === 1'b1) pulses++;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 0, 1'b0);
            if (valid4 === 1'b1) pulses++;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL gap_pulses got %0d want 2", pulses); end
        checks++; if (fill4 !== 3'd2 || primed4 !== 1'b0) begin errors++; $display("FAIL gap_fill got %0d/%b want 2/0", fill4, primed4); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1, 1'b0);
        cycle(1'b1, 2, 1'b0);
        cycle(1'b1, 3, 1'b0);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (taps4 !== 32'd0 || pair4 !== 18'd0) begin errors++; $display("FAIL arst_data got %h/%h want 0", taps4, pair4); end
        checks++; if (valid4 !== 1'b0 || fill4 !== 3'd0 || primed4 !== 1'b0) begin errors++; $display("FAIL arst_ctrl got %b/%0d/%b want 0", valid4, fill4, primed4); end
        #1 rst = 1'b1;
        model_reset();
        cycle(1'b1, 9, 1'b0);
        checks++; if (taps4[7:0] !== 8'd9 || taps4[15:8] !== 8'd0) begin errors++; $display("FAIL arst_push got %h want 00000009", taps4); end
        checks++; if (fill4 !== 3'd1) begin errors++; $display("FAIL arst_fill got %0d want 1", fill4); end
    endtask

`ifdef SYM_TAP_CLEAR_EN
    task automatic test_clear();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, i * 10, 1'b0);
        cycle(1'b1, 7, 1'b1);
        checks++; if (taps4 !== 32'd0 || taps5 !== 40'd0) begin errors++; $display("FAIL clr_taps got %h/%h want 0", taps4, taps5); end
        checks++; if (fill4 !== 3'd0 || valid4 !== 1'b0 || pair4 !== 18'd0) begin errors++; $display("FAIL clr_ctrl got %0d/%b/%h want 0", fill4, valid4, pair4); end
        cycle(1'b0, 0, 1'b0);
        checks++; if (valid4 !== 1'b0 || taps4 !== 32'd0) begin errors++; $display("FAIL clr_after got %b/%h want 0/0", valid4, taps4); end
    endtask
`endif

    task automatic test_random();
        bit e, c;
        int s;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            e = ($urandom_range(0, 9) < 7);
            s = int'($urandom_range(0, 255)) - 128;
`ifdef SYM_TAP_CLEAR_EN
            c = ($urandom_range(0, 29) == 0);
`else
            c = 1'b0;
`endif
            cycle(e, s, c);
            checks++; if (taps4 !== x_taps4) begin errors++; $display("FAIL rnd_taps4 n=%0d got %h want %h", n, taps4, x_taps4); end
            checks++; if (pair4 !== x_pair4) begin errors++; $display("FAIL rnd_pair4 n=%0d got %h want %h", n, pair4, x_pair4); end
            checks++; if (taps5 !== x_taps5) begin errors++; $display("FAIL rnd_taps5 n=%0d got %h want %h", n, taps5, x_taps5); end
            checks++; if (pair5 !== x_pair5) begin errors++; $display("FAIL rnd_pair5 n=%0d got %h want %h", n, pair5, x_pair5); end
            checks++; if (valid4 !== v || valid5 !== v) begin errors++; $display("FAIL rnd_valid n=%0d got %b/%b want %b", n, valid4, valid5, v); end
            checks++; if (fill4 !== 3'(f4) || primed4 !== (f4 == 4)) begin errors++; $display("FAIL rnd_fill4 n=%0d got %0d/%b want %0d", n, fill4, primed4, f4); end
            checks++; if (fill5 !== 3'(f5) || primed5 !== (f5 == 5)) begin errors++; $display("FAIL rnd_fill5 n=%0d got %0d/%b want %0d", n, fill5, primed5, f5); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_extremes();
        test_gaps();
        test_async_reset();
`ifdef SYM_TAP_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
